hilo_mdu_ctrl: RTL and testbench
================================

# hilo_mdu_ctrl

Multiply/divide sequencer and HI/LO register owner for the execute stage. It accepts decoded mult/multu/div/divu/mul/mthi/mtlo operations and runs a multi-cycle multiply or a 32-iteration restoring divide. It stalls the pipeline until the result is ready, then commits HI/LO or returns the `mul` GPR result. It supports cancellation from exception/flush logic.

## Interface

Parameters:
- `MUL_CYCLES`, default 2: cycles from accept to `done` for mult/multu/mul; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `op_valid`  in  1  execute stage presents an MDU op this cycle; held stable while `stall`=1.
- `op`  in  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 mul; 000 is ignored.
- `src_a`  in  32  rs operand; held while `stall`=1.
- `src_b`  in  32  rt operand; held while `stall`=1.
- `cancel`  in  1  flush/exception; aborts the current or presented op with no commit.
- `stall`  out  1  combinational; execute must hold its instruction.
- `done`  out  1  one-cycle completion pulse for long ops.
- `mul_result`  out  32  low product word for `mul`; valid only while `done`=1.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.
- `busy`  out  1  state != IDLE.

## Operation

- States: IDLE, MUL, DIV, FIN.
- Long op means `op` is 001, 010, 011, 100 or 111.
- **IDLE**, `op_valid` & !`cancel`:
  - mthi/mtlo: write `src_a` to `hi`/`lo` at the edge; no stall, no `done`.
  - mult/multu/mul: register the 64-bit product (signed for mult/mul, unsigned for multu); load counter = `MUL_CYCLES`-1. Go to FIN if `MUL_CYCLES`=1, else MUL.
  - div/divu: latch |a| and |b| (raw values for divu), result signs, and the op; clear the remainder; counter=32; go to DIV.
- **MUL**: decrement the counter; go to FIN when it reaches 0.
- **DIV**: one restoring step per cycle: shift {rem,quo} left; subtract the divisor if rem ≥ divisor and set the quotient bit. After 32 steps go to FIN.
- **FIN**: `done`=1 unless `cancel`.
  - Divide sign fix: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - At the edge, mult/multu/div/divu write HI/LO: HI=remainder and LO=quotient for divides, HI=product[63:32] and LO=product[31:0] for multiplies.
  - mul writes nothing to HI/LO; `mul_result`=product[31:0].
  - Return to IDLE.
- Divide by zero, both div and divu: LO=0xFFFFFFFF, HI=`src_a` (raw dividend).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `cancel` in any state or in the accept cycle:
  - next state is IDLE;
  - no HI/LO write, `done`=0;
  - an mthi/mtlo presented with `cancel` is dropped.
- `stall` = (IDLE & `op_valid` & long op & !`cancel`) | (MUL | DIV).
  - `stall`=0 in FIN, so the pipeline advances in the `done` cycle.
  - An `op_valid` in the cycle after FIN is a new instruction.
- `op_valid` is ignored outside IDLE; the held op is already captured.

## Timing

- Reset values: state IDLE; `hi`=`lo`=0; counter 0; `done`=0; `busy`=0; `mul_result`=0. `stall`=0 whenever `op_valid`=0.
- Async `reset` mid-operation aborts immediately, with no commit.
- The accept cycle is cycle 0.
- Multiplies: `done` in cycle `MUL_CYCLES`; `stall` in cycles 0..`MUL_CYCLES`-1.
- Divides: `done` in cycle 33; `stall` in cycles 0..32 (33 stall cycles).
- `hi`/`lo` show new values from the cycle after `done`. An mfhi/mflo in the next instruction reads the committed value with no extra forwarding.
- mthi/mtlo: `hi`/`lo` updated in cycle 1; back-to-back mthi/mtlo each take one cycle.
- `cancel` in the FIN cycle suppresses `done` and the commit for that same cycle.

## Test plan

- mult `src_a`=0xFFFFFFFB (-5), `src_b`=3, `MUL_CYCLES`=2 -> `stall` cycles 0–1, `done` cycle 2, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; mul 7×6 -> `mul_result`=42 during `done`, HI/LO unchanged.
- div -7/2 -> 33 `stall` cycles, `done` at cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu 100/0 -> LO=0xFFFFFFFF, HI=100.
- Signed overflow div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; divu 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0.
- mthi 0x1234, then div started with `cancel` pulsed in cycle 10 -> no `done`, HI stays 0x1234, `busy`=0 next cycle, and a following mtlo 0x55 is accepted with LO=0x55 one cycle later.
- Async `reset` asserted in DIV cycle 20 -> immediately IDLE, HI=LO=0, `stall`=0; a fresh mult after reset completes with correct values.

Source files
------------

// File: rtl/hilo_mdu_ctrl_if.sv
// Execute-stage <-> MDU handshake: op request, cancel, stall/done and architectural HI/LO.
// The execute stage drives master; the MDU drives slave. Stall is the only backpressure.
interface hilo_mdu_ctrl_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stall;
  logic        done;
  logic [31:0] mul_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output op_valid, op, src_a, src_b, cancel,
    input  stall, done, mul_result, hi, lo, busy
  );

  modport slave (
    input  op_valid, op, src_a, src_b, cancel,
    output stall, done, mul_result, hi, lo, busy
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// MDU sequencer and HI/LO owner: multiply done after MUL_CYCLES, 32-step restoring divide done at cycle 33.
// Holds execute via combinational stall until the FIN cycle; cancel aborts with no commit.
module hilo_mdu_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  hilo_mdu_ctrl_if.slave mdu
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  state_t      state, state_n;
  logic [5:0]  cnt;
  logic [2:0]  op_r;
  logic [63:0] prod;
  logic [31:0] rem, quo, dvsr;
  logic [31:0] hi_r, lo_r;
  logic        q_neg, r_neg, dvz;

  logic        accept, is_mul, is_div, sdiv, smul;
  logic        stall, done;
  logic [63:0] ma, mb, prod_full;
  logic [31:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [32:0] rem_sh, rem_sub;

  assign accept = (state == IDLE) && mdu.op_valid && !mdu.cancel;
  assign is_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU) || (mdu.op == OP_MUL);
  assign is_div = (mdu.op == OP_DIV) || (mdu.op == OP_DIVU);
  assign sdiv   = (mdu.op == OP_DIV);
  assign smul   = (mdu.op != OP_MULTU);

  // Low 64 bits of the product of 64-bit extended operands is exact for both signednesses.
  assign ma        = {{32{smul & mdu.src_a[31]}}, mdu.src_a};
  assign mb        = {{32{smul & mdu.src_b[31]}}, mdu.src_b};
  assign prod_full = ma * mb;

  assign abs_a = (sdiv && mdu.src_a[31]) ? -mdu.src_a : mdu.src_a;
  assign abs_b = (sdiv && mdu.src_b[31]) ? -mdu.src_b : mdu.src_b;

  assign rem_sh  = {rem, quo[31]};
  assign rem_sub = rem_sh - {1'b0, dvsr};

  // With a zero divisor the remainder ends as |a|, so the sign fix restores the raw dividend.
  assign quo_fix = q_neg ? -quo : quo;
  assign rem_fix = r_neg ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_n = (MUL_CYCLES == 1) ? FIN : MUL;
          stall   = 1'b1;
        end else if (accept && is_div) begin
          state_n = DIV;
          stall   = 1'b1;
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (cnt <= 6'd1) state_n = FIN;
      end
      FIN: begin
        done    = !mdu.cancel;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (mdu.cancel) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      op_r  <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dvz   <= 1'b0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= mdu.op;
            if (mdu.op == OP_MTHI) hi_r <= mdu.src_a;
            if (mdu.op == OP_MTLO) lo_r <= mdu.src_a;
            if (is_mul) begin
              prod <= prod_full;
              cnt  <= 6'(MUL_CYCLES - 1);
            end
            if (is_div) begin
              quo   <= abs_a;
              dvsr  <= abs_b;
              rem   <= '0;
              cnt   <= 6'd32;
              q_neg <= sdiv & (mdu.src_a[31] ^ mdu.src_b[31]);
              r_neg <= sdiv & mdu.src_a[31];
              dvz   <= (mdu.src_b == 32'd0);
            end
          end
        end
        MUL: cnt <= cnt - 6'd1;
        DIV: begin
          cnt <= cnt - 6'd1;
          rem <= rem_sub[32] ? rem_sh[31:0] : rem_sub[31:0];
          quo <= {quo[30:0], !rem_sub[32]};
        end
        FIN: begin
          if (!mdu.cancel && op_r != OP_MUL) begin
            if (op_r == OP_DIV || op_r == OP_DIVU) begin
              hi_r <= rem_fix;
              lo_r <= dvz ? 32'hFFFF_FFFF : quo_fix;
            end else begin
              hi_r <= prod[63:32];
              lo_r <= prod[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.stall      = stall;
  assign mdu.done       = done;
  assign mdu.mul_result = (done && op_r == OP_MUL) ? prod[31:0] : 32'd0;
  assign mdu.hi         = hi_r;
  assign mdu.lo         = lo_r;
  assign mdu.busy       = (state != IDLE);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: directed test-plan vectors plus random ops against an arithmetic HI/LO model.
module tb_hilo_mdu_ctrl;
  localparam int MC = 2;
  localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4;
  localparam logic [2:0] MTHI = 3'd5, MTLO = 3'd6, MUL = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  hilo_mdu_ctrl_if m();

  hilo_mdu_ctrl #(.MUL_CYCLES(MC)) dut (.clk(clk), .reset(reset), .mdu(m));

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mr, output int ed, output int es);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mr = '0; ed = -1; es = 0;
    case (o)
      MULT, MUL: begin
        p = sa * sb; ed = MC; es = MC;
        if (o == MULT) begin m_hi = p[63:32]; m_lo = p[31:0]; end
        else mr = p[31:0];
      end
      MULTU: begin
        up = {32'h0, a} * {32'h0, b}; ed = MC; es = MC;
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      DIV, DIVU: begin
        ed = 33; es = 33;
        if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (o == DIV) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Presents one instruction from posedge+1; returns at posedge+1 of the cycle after it advanced.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_cyc, output int dc, output int sc,
                        output logic [31:0] mr, output bit tmo);
    int c;
    bit fin;
    dc = -1; sc = 0; mr = '0; tmo = 1'b0; fin = 1'b0; c = 0;
    m.op_valid = 1'b1; m.op = o; m.src_a = a; m.src_b = b;
    while (!fin) begin
      m.cancel = (c == cancel_cyc);
      @(negedge clk);
      if (m.stall) sc++;
      if (m.done) begin dc = c; mr = m.mul_result; end
      if (!m.stall || m.cancel) fin = 1'b1;
      @(posedge clk); #1;
      c++;
      if (c > 60) begin tmo = 1'b1; fin = 1'b1; end
    end
    m.op_valid = 1'b0; m.op = '0; m.cancel = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (m.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", m.hi); end
    checks++; if (m.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", m.lo); end
    checks++; if (m.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", m.busy); end
    checks++; if (m.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", m.done); end
    checks++; if (m.mul_result !== 32'd0) begin failures++; $display("FAIL reset_mulres got=%h exp=0", m.mul_result); end
    reset = 1'b0;
    m.op = MULT;
    @(negedge clk);
    checks++; if (m.stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", m.stall); end
    @(posedge clk); #1;
    m.op = '0;
    checks++; if (m.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", m.busy); end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [11] = '{MULT, MULTU, MUL, DIV, DIVU, DIV, DIVU, DIV, DIV, MTHI, MTLO};
    logic [31:0] t_a  [11] = '{32'hFFFFFFFB, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'd100, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFF7, 32'd7, 32'h1234, 32'h55};
    logic [31:0] t_b  [11] = '{32'd3, 32'hFFFFFFFF, 32'd6, 32'd2, 32'd0, 32'hFFFFFFFF,
                               32'd1, 32'd0, 32'hFFFFFFFE, 32'd0, 32'd0};
    logic [31:0] t_hi [11] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd100, 32'd0,
                               32'd0, 32'hFFFFFFF7, 32'd1, 32'h1234, 32'h1234};
    logic [31:0] t_lo [11] = '{32'hFFFFFFF1, 32'h00000001, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h55};
    logic [31:0] emr, mr;
    int ed, es, dc, sc;
    bit tmo;
    for (int i = 0; i < 11; i++) begin
      model(t_op[i], t_a[i], t_b[i], emr, ed, es);
      run_op(t_op[i], t_a[i], t_b[i], -1, dc, sc, mr, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL dir_timeout idx=%0d", i); end
      checks++; if (dc !== ed) begin failures++; $display("FAIL dir_done_cycle idx=%0d got=%0d exp=%0d", i, dc, ed); end
      checks++; if (sc !== es) begin failures++; $display("FAIL dir_stall_cycles idx=%0d got=%0d exp=%0d", i, sc, es); end
      checks++; if (m.hi !== t_hi[i]) begin failures++; $display("FAIL dir_hi idx=%0d got=%h exp=%h", i, m.hi, t_hi[i]); end
      checks++; if (m.lo !== t_lo[i]) begin failures++; $display("FAIL dir_lo idx=%0d got=%h exp=%h", i, m.lo, t_lo[i]); end
      if (t_op[i] == MUL) begin
        checks++; if (mr !== 32'd42) begin failures++; $display("FAIL dir_mul_result got=%h exp=2a", mr); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] emr, mr;
    int ed, es, dc, sc;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] o;
      logic [31:0] v;
      o = (i % 2 == 0) ? MTHI : MTLO;
      v = $urandom;
      model(o, v, 32'd0, emr, ed, es);
      run_op(o, v, 32'd0, -1, dc, sc, mr, tmo);
      checks++; if (sc !== 0) begin failures++; $display("FAIL b2b_stall idx=%0d got=%0d exp=0", i, sc); end
      checks++; if ((o == MTHI ? m.hi : m.lo) !== v) begin
        failures++; $display("FAIL b2b_write idx=%0d got_hi=%h got_lo=%h exp=%h", i, m.hi, m.lo, v);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] emr, mr, a, b;
    logic [2:0] o;
    int ed, es, dc, sc;
    bit tmo;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(o, a, b, emr, ed, es);
      run_op(o, a, b, -1, dc, sc, mr, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rnd_timeout op=%0d", o); end
      checks++; if (dc !== ed) begin failures++; $display("FAIL rnd_done_cycle op=%0d got=%0d exp=%0d", o, dc, ed); end
      checks++; if (sc !== es) begin failures++; $display("FAIL rnd_stall_cycles op=%0d got=%0d exp=%0d", o, sc, es); end
      checks++; if (m.hi !== m_hi) begin failures++; $display("FAIL rnd_hi op=%0d a=%h b=%h got=%h exp=%h", o, a, b, m.hi, m_hi); end
      checks++; if (m.lo !== m_lo) begin failures++; $display("FAIL rnd_lo op=%0d a=%h b=%h got=%h exp=%h", o, a, b, m.lo, m_lo); end
      if (o == MUL) begin
        checks++; if (mr !== emr) begin failures++; $display("FAIL rnd_mul_result a=%h b=%h got=%h exp=%h", a, b, mr, emr); end
      end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] emr, mr, hi0, lo0;
    int ed, es, dc, sc;
    bit tmo;
    model(MTHI, 32'h1234, 32'd0, emr, ed, es);
    run_op(MTHI, 32'h1234, 32'd0, -1, dc, sc, mr, tmo);
    lo0 = m_lo;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 10, dc, sc, mr, tmo);
    checks++; if (dc !== -1) begin failures++; $display("FAIL cancel_div_done got=%0d exp=-1", dc); end
    checks++; if (m.busy !== 1'b0) begin failures++; $display("FAIL cancel_div_busy got=%b exp=0", m.busy); end
    checks++; if (m.hi !== 32'h1234) begin failures++; $display("FAIL cancel_div_hi got=%h exp=1234", m.hi); end
    checks++; if (m.lo !== lo0) begin failures++; $display("FAIL cancel_div_lo got=%h exp=%h", m.lo, lo0); end
    model(MTLO, 32'h55, 32'd0, emr, ed, es);
    run_op(MTLO, 32'h55, 32'd0, -1, dc, sc, mr, tmo);
    checks++; if (m.lo !== 32'h55) begin failures++; $display("FAIL cancel_then_mtlo got=%h exp=55", m.lo); end
    run_op(MTHI, 32'hDEAD, 32'd0, 0, dc, sc, mr, tmo);
    checks++; if (m.hi !== 32'h1234) begin failures++; $display("FAIL cancel_mthi_drop got=%h exp=1234", m.hi); end
    hi0 = m_hi; lo0 = m_lo;
    run_op(MULT, 32'd9, 32'd9, MC, dc, sc, mr, tmo);
    checks++; if (dc !== -1) begin failures++; $display("FAIL cancel_fin_done got=%0d exp=-1", dc); end
    checks++; if ({m.hi, m.lo} !== {hi0, lo0}) begin
      failures++; $display("FAIL cancel_fin_commit got=%h_%h exp=%h_%h", m.hi, m.lo, hi0, lo0);
    end
    run_op(DIVU, 32'd50, 32'd5, 0, dc, sc, mr, tmo);
    checks++; if (sc !== 0 || m.busy !== 1'b0) begin
      failures++; $display("FAIL cancel_accept got_stall=%0d got_busy=%b exp=0/0", sc, m.busy);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] emr, mr;
    int ed, es, dc, sc;
    bit tmo;
    model(MTHI, 32'hAAAA, 32'd0, emr, ed, es);
    run_op(MTHI, 32'hAAAA, 32'd0, -1, dc, sc, mr, tmo);
    m.op_valid = 1'b1; m.op = DIV; m.src_a = 32'hFFFFFFF9; m.src_b = 32'd2;
    repeat (20) begin @(posedge clk); #1; end
    checks++; if (m.busy !== 1'b1 || m.stall !== 1'b1) begin
      failures++; $display("FAIL arst_pre got_busy=%b got_stall=%b exp=1/1", m.busy, m.stall);
    end
    #2;
    reset = 1'b1; m.op_valid = 1'b0; m.op = '0;
    #1;
    checks++; if (m.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", m.busy); end
    checks++; if (m.stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", m.stall); end
    checks++; if ({m.hi, m.lo} !== 64'd0) begin failures++; $display("FAIL arst_hilo got=%h_%h exp=0", m.hi, m.lo); end
    checks++; if (m.done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", m.done); end
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    model(MULT, 32'hFFFF0000, 32'h00012345, emr, ed, es);
    run_op(MULT, 32'hFFFF0000, 32'h00012345, -1, dc, sc, mr, tmo);
    checks++; if (dc !== MC || tmo !== 1'b0) begin failures++; $display("FAIL arst_mult_done got=%0d exp=%0d", dc, MC); end
    checks++; if ({m.hi, m.lo} !== {m_hi, m_lo}) begin
      failures++; $display("FAIL arst_mult_hilo got=%h_%h exp=%h_%h", m.hi, m.lo, m_hi, m_lo);
    end
  endtask

  initial begin
    reset = 1'b1;
    m.op_valid = 1'b0; m.op = '0; m.src_a = '0; m.src_b = '0; m.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_cancel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
